dlx_alu_pipe: RTL

Parametrised, handshaked successor of the DLX execute-stage ALU. Adds valid/ready flow control, a registered result stage, signed-overflow and zero flags, and an iterative 1-bit-per-cycle shifter (SLL/SRL/SRA) driven by a small FSM. Sits between decode/operand fetch and the memory/writeback stage. Also sign/zero-extends load data on the MEM_READ path.

---
 rtl/dlx_alu_pkg.sv | 46 ++++
 rtl/dlx_alu_shift.sv | 126 ++++++++++++
 rtl/dlx_alu_pipe.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dlx_alu_pkg.sv
// ---------------------------------------------------------------------------
// dlx_alu_pkg
// Shared constants for the pipelined DLX execute-stage ALU:
//   - ALUSEL_* : operation class codes on alusel
//   - ALUOP_*  : arithmetic/logic operation codes on aluop
//   - LOAD_*   : load extension codes on aluop[2:0] for the MEM_READ class
//   - STATE_*  : shift FSM state encodings
//   - shift_kind_e / is_shift_op : helpers for the iterative shifter
// ---------------------------------------------------------------------------
package dlx_alu_pkg;

    localparam logic [2:0] ALUSEL_ARITH_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_MEM_READ    = 3'b101;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_HADD = 4'd1;
    localparam logic [3:0] ALUOP_SUB  = 4'd2;
    localparam logic [3:0] ALUOP_NOT  = 4'd3;
    localparam logic [3:0] ALUOP_AND  = 4'd4;
    localparam logic [3:0] ALUOP_OR   = 4'd5;
    localparam logic [3:0] ALUOP_XOR  = 4'd6;
    localparam logic [3:0] ALUOP_LHG  = 4'd7;
    localparam logic [3:0] ALUOP_SLL  = 4'd8;
    localparam logic [3:0] ALUOP_SRL  = 4'd9;
    localparam logic [3:0] ALUOP_SRA  = 4'd10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b011;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_SHIFT = 1'b1;

    typedef enum logic [1:0] {
        SHIFT_SLL,
        SHIFT_SRL,
        SHIFT_SRA
    } shift_kind_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALUOP_SLL) || (op == ALUOP_SRL) || (op == ALUOP_SRA);
    endfunction

endpackage

// File: rtl/dlx_alu_shift.sv
// ---------------------------------------------------------------------------
// dlx_alu_shift
// Iterative one-bit-per-cycle shifter (SLL/SRL/SRA) with a two-state FSM.
// The parent owns the handshake and the output register; this block only
// reports when its result may be loaded.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   en_i           : stage enable, 0 freezes all state
//   start_i        : load operand and amount, IDLE -> SHIFT (amount must be > 0)
//   kind_i         : shift flavour
//   data_i         : value to shift
//   amount_i       : number of single-bit steps
//   slot_free_i    : parent output register can take a result this cycle
//   busy_o         : FSM not in IDLE
//   done_o         : result_o/cout_o are loaded by the parent on this edge
//   result_o       : shifted value (valid while done_o)
//   cout_o         : last bit shifted out (valid while done_o)
// ---------------------------------------------------------------------------
module dlx_alu_shift
    import dlx_alu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               start_i,
    input  shift_kind_e        kind_i,
    input  logic [DW-1:0]      data_i,
    input  logic [SHAMT_W-1:0] amount_i,
    input  logic               slot_free_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [DW-1:0]      result_o,
    output logic               cout_o
);

    logic [0:0]         state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [DW-1:0]      data_q, data_d;
    shift_kind_e        kind_q, kind_d;
    logic               last_q, last_d;

    logic [DW-1:0]      shifted;
    logic               out_bit;

    // One-bit step of the currently held value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        shifted = data_q;
        out_bit = 1'b0;
        case (kind_q)
            SHIFT_SLL: begin
                shifted = {data_q[DW-2:0], 1'b0};
                out_bit = data_q[DW-1];
            end
            SHIFT_SRL: begin
                shifted = {1'b0, data_q[DW-1:1]};
                out_bit = data_q[0];
            end
            SHIFT_SRA: begin
                shifted = {data_q[DW-1], data_q[DW-1:1]};
                out_bit = data_q[0];
            end
            default: begin
                shifted = data_q;
                out_bit = 1'b0;
            end
        endcase
    end

    assign busy_o = (state_q == STATE_SHIFT);

    // With one step left the final shift is taken on the loading edge itself.
    // count==0 in SHIFT means the result was finished while the output slot
    // was occupied and is waiting in data_q.
    assign done_o   = busy_o && en_i && slot_free_i && (count_q <= SHAMT_W'(1));
    assign result_o = (count_q == '0) ? data_q : shifted;
    assign cout_o   = (count_q == '0) ? last_q : out_bit;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        kind_d  = kind_q;
        last_d  = last_q;
        if (state_q == STATE_IDLE) begin
            if (start_i) begin
                state_d = STATE_SHIFT;
                count_d = amount_i;
                data_d  = data_i;
                kind_d  = kind_i;
                last_d  = 1'b0;
            end
        end else if (count_q != '0) begin
            data_d  = shifted;
            last_d  = out_bit;
            count_d = count_q - SHAMT_W'(1);
        end
        if (done_o) begin
            state_d = STATE_IDLE;
        end
    end

    // NOTE: the shift data register is reset along with the control state;
    // it is a single word, so clearing it costs nothing and keeps it known.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STATE_IDLE;
            count_q <= '0;
            data_q  <= '0;
            kind_q  <= SHIFT_SLL;
            last_q  <= 1'b0;
        end else if (en_i) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            kind_q  <= kind_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: rtl/dlx_alu_pipe.sv
// ---------------------------------------------------------------------------
// dlx_alu_pipe
// Handshaked DLX execute-stage ALU with a registered result stage, carry,
// signed-overflow and zero flags, an iterative shifter and load extension.
// Optional build macro: DLX_ALU_SAT_EN -- ADD/SUB saturate on signed overflow.
// Ports:
//   clk2, rst2      : clock, asynchronous active-high reset
//   en_ar           : stage enable, 0 freezes all state
//   in_valid/ready  : operand bundle handshake
//   aluin1, aluin2  : operand A, operand B / load data
//   aluop, alusel   : operation code and class
//   shift_nos       : shift amount
//   out_valid/ready : result handshake
//   aluout_ar       : registered result
//   carry, ovf, zero: registered flags
//   busy            : shift FSM active
// ---------------------------------------------------------------------------
module dlx_alu_pipe
    import dlx_alu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk2,
    input  logic               rst2,
    input  logic               en_ar,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      aluin1,
    input  logic [DW-1:0]      aluin2,
    input  logic [3:0]         aluop,
    input  logic [2:0]         alusel,
    input  logic [SHAMT_W-1:0] shift_nos,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      aluout_ar,
    output logic               carry,
    output logic               ovf,
    output logic               zero,
    output logic               busy
);

    localparam int H = DW / 2;

`ifdef DLX_ALU_SAT_EN
    localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};
`endif

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] aluout_q, aluout_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic          slot_free, accept, pop, is_shift, start_shift, load;
    logic          sh_busy, sh_done, sh_cout;
    logic [DW-1:0] sh_result;
    shift_kind_e   sh_kind;

    logic [DW:0]   sum_w, diff_w;
    logic [H:0]    hsum_w;
    logic          add_ovf, sub_ovf;
    logic [DW-1:0] res_c;
    logic          carry_c, ovf_c;

    // Handshake: the output slot is free when empty or being drained now.
    assign slot_free   = !out_valid_q || out_ready;
    assign in_ready    = en_ar && !sh_busy && slot_free;
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid_q && out_ready && en_ar;
    assign is_shift    = (alusel == ALUSEL_ARITH_LOGIC) && is_shift_op(aluop);
    assign start_shift = accept && is_shift && (shift_nos != '0);
    assign load        = (accept && !start_shift) || sh_done;

    assign sh_kind = (aluop == ALUOP_SLL) ? SHIFT_SLL :
                     (aluop == ALUOP_SRL) ? SHIFT_SRL : SHIFT_SRA;

    dlx_alu_shift #(
        .DW      (DW),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk_i       (clk2),
        .rst_i       (rst2),
        .en_i        (en_ar),
        .start_i     (start_shift),
        .kind_i      (sh_kind),
        .data_i      (aluin1),
        .amount_i    (shift_nos),
        .slot_free_i (slot_free),
        .busy_o      (sh_busy),
        .done_o      (sh_done),
        .result_o    (sh_result),
        .cout_o      (sh_cout)
    );

    // Widened adders expose the carry/borrow as the top bit.
    assign sum_w   = {1'b0, aluin1} + {1'b0, aluin2};
    assign diff_w  = {1'b0, aluin1} - {1'b0, aluin2};
    assign hsum_w  = {1'b0, aluin1[H-1:0]} + {1'b0, aluin2[H-1:0]};
    assign add_ovf = (aluin1[DW-1] == aluin2[DW-1]) && (sum_w[DW-1] != aluin1[DW-1]);
    assign sub_ovf = (aluin1[DW-1] != aluin2[DW-1]) && (diff_w[DW-1] != aluin1[DW-1]);

    // Single-cycle result; shifts here only cover a zero shift amount.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (alusel)
            ALUSEL_ARITH_LOGIC: begin
                case (aluop)
                    ALUOP_ADD: begin
                        res_c   = sum_w[DW-1:0];
                        carry_c = sum_w[DW];
                        ovf_c   = add_ovf;
`ifdef DLX_ALU_SAT_EN
                        // On overflow the true result has the sign of A.
                        if (add_ovf) res_c = aluin1[DW-1] ? SAT_MIN : SAT_MAX;
`endif
                    end
                    ALUOP_SUB: begin
                        res_c   = diff_w[DW-1:0];
                        carry_c = diff_w[DW];
                        ovf_c   = sub_ovf;
`ifdef DLX_ALU_SAT_EN
                        if (sub_ovf) res_c = aluin1[DW-1] ? SAT_MIN : SAT_MAX;
`endif
                    end
                    ALUOP_HADD: begin
                        res_c   = {{H{hsum_w[H-1]}}, hsum_w[H-1:0]};
                        carry_c = hsum_w[H];
                    end
                    ALUOP_NOT: res_c = ~aluin2;
                    ALUOP_AND: res_c = aluin1 & aluin2;
                    ALUOP_OR:  res_c = aluin1 | aluin2;
                    ALUOP_XOR: res_c = aluin1 ^ aluin2;
                    ALUOP_LHG: res_c = {aluin2[H-1:0], {H{1'b0}}};
                    ALUOP_SLL, ALUOP_SRL, ALUOP_SRA: res_c = aluin1;
                    default:   res_c = '0;
                endcase
            end
            ALUSEL_MEM_READ: begin
                case (aluop[2:0])
                    LOAD_LB:  res_c = {{(DW-8){aluin2[7]}}, aluin2[7:0]};
                    LOAD_LBU: res_c = {{(DW-8){1'b0}}, aluin2[7:0]};
                    LOAD_LH:  res_c = {{(DW-16){aluin2[15]}}, aluin2[15:0]};
                    LOAD_LHU: res_c = {{(DW-16){1'b0}}, aluin2[15:0]};
                    default:  res_c = aluin2;
                endcase
            end
            default: res_c = aluin2;
        endcase
    end

    // Output register: a load wins over a pop, giving one result per cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        aluout_d    = aluout_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (load) begin
            out_valid_d = 1'b1;
            aluout_d    = sh_done ? sh_result : res_c;
            carry_d     = sh_done ? sh_cout : carry_c;
            ovf_d       = sh_done ? 1'b0 : ovf_c;
            zero_d      = (aluout_d == '0);
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk2 or posedge rst2) begin
        if (rst2) begin
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en_ar) begin
            out_valid_q <= out_valid_d;
            aluout_q    <= aluout_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q && en_ar;
    assign aluout_ar = aluout_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign busy      = sh_busy;

endmodule
